// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM encoding, default operand width and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_WIDTH = 32;

  // Divide-by-zero quotient is all ones at any width; replicate this bit.
  localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted  = {rem, din};
  // When the subtraction succeeds the result is below divisor, so the low bits suffice.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: magnitudes go through WIDTH restoring
// steps, signs are applied in FIX, and results are published in DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  // q_reg starts as the dividend and fills with quotient bits from the LSB.
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] b_reg;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;

  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_reg),
    .din      (q_reg[WIDTH-1]),
    .divisor  (b_reg),
    .rem_next (r_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      cnt         <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      b_reg       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op & dividend[WIDTH-1];
            cnt   <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              q_reg <= {WIDTH{DBZ_QUOT_FILL}};
              r_reg <= dividend;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              q_reg <= (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
              b_reg <= (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;
              r_reg <= '0;
              dbz   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          q_reg <= {q_reg[WIDTH-2:0], q_bit};
          r_reg <= r_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (neg_q) q_reg <= -q_reg;
          if (neg_r) r_reg <= -r_reg;
          state <= DONE;
        end
        DONE: begin
          quotient    <= q_reg;
          remainder   <= r_reg;
          div_by_zero <= dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, signed/unsigned
// results, divide-by-zero, abort via clr, ignored start and back-to-back ops.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int vecs = 0;
  int errs = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  // Launch one operation, scramble operands after acceptance, wait for done.
  // lat = edges after the start edge until done is seen (-1 on timeout).
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_gaps);
    signed_op = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0001; signed_op = ~s;
    lat = -1; busy_gaps = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (!busy) busy_gaps++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
    vecs++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    vecs++; if (quotient !== 32'h0) begin errs++; $display("FAIL reset_quot got=%h exp=0", quotient); end
    vecs++; if (remainder !== 32'h0) begin errs++; $display("FAIL reset_rem got=%h exp=0", remainder); end
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, gaps;
    do_op(1'b0, 32'd100, 32'd7, lat, gaps);
    vecs++; if (lat !== 34) begin errs++; $display("FAIL u100_7_latency got=%0d exp=34", lat); end
    vecs++; if (gaps !== 0) begin errs++; $display("FAIL u100_7_busy_low_cycles got=%0d exp=0", gaps); end
    vecs++; if (quotient !== 32'h0000_000E) begin errs++; $display("FAIL u100_7_quot got=%h exp=0000000e", quotient); end
    vecs++; if (remainder !== 32'h0000_0002) begin errs++; $display("FAIL u100_7_rem got=%h exp=00000002", remainder); end
    vecs++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL u100_7_dbz got=%b exp=0", div_by_zero); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL u100_7_busy_at_done got=%b exp=0", busy); end
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, lat, gaps);
    vecs++; if (quotient !== 32'h7FFF_FFFF) begin errs++; $display("FAIL umax_2_quot got=%h exp=7fffffff", quotient); end
    vecs++; if (remainder !== 32'h0000_0001) begin errs++; $display("FAIL umax_2_rem got=%h exp=00000001", remainder); end
  endtask

  task automatic test_signed();
    int lat, gaps;
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, gaps);
    vecs++; if (lat !== 34) begin errs++; $display("FAIL sm100_7_latency got=%0d exp=34", lat); end
    vecs++; if (quotient !== 32'hFFFF_FFF2) begin errs++; $display("FAIL sm100_7_quot got=%h exp=fffffff2", quotient); end
    vecs++; if (remainder !== 32'hFFFF_FFFE) begin errs++; $display("FAIL sm100_7_rem got=%h exp=fffffffe", remainder); end
    do_op(1'b1, 32'd100, 32'hFFFF_FFF9, lat, gaps);
    vecs++; if (quotient !== 32'hFFFF_FFF2) begin errs++; $display("FAIL s100_m7_quot got=%h exp=fffffff2", quotient); end
    vecs++; if (remainder !== 32'h0000_0002) begin errs++; $display("FAIL s100_m7_rem got=%h exp=00000002", remainder); end
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, gaps);
    vecs++; if (quotient !== 32'h8000_0000) begin errs++; $display("FAIL sovf_quot got=%h exp=80000000", quotient); end
    vecs++; if (remainder !== 32'h0) begin errs++; $display("FAIL sovf_rem got=%h exp=00000000", remainder); end
    vecs++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL sovf_dbz got=%b exp=0", div_by_zero); end
    // Signed with both operands negative: -100 / -7 = 14 r -2
    do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, gaps);
    vecs++; if (quotient !== 32'h0000_000E) begin errs++; $display("FAIL sm100_m7_quot got=%h exp=0000000e", quotient); end
    vecs++; if (remainder !== 32'hFFFF_FFFE) begin errs++; $display("FAIL sm100_m7_rem got=%h exp=fffffffe", remainder); end
  endtask

  task automatic test_div_zero();
    int lat, gaps;
    do_op(1'b0, 32'h0000_1234, 32'h0, lat, gaps);
    vecs++; if (lat !== 1) begin errs++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    vecs++; if (div_by_zero !== 1'b1) begin errs++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    vecs++; if (quotient !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dbz_quot got=%h exp=ffffffff", quotient); end
    vecs++; if (remainder !== 32'h0000_1234) begin errs++; $display("FAIL dbz_rem got=%h exp=00001234", remainder); end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL hold_done_pulse got=%b exp=0", done); end
    repeat (5) @(posedge clk);
    #1;
    vecs++; if (div_by_zero !== 1'b1) begin errs++; $display("FAIL hold_dbz got=%b exp=1", div_by_zero); end
    vecs++; if (quotient !== 32'hFFFF_FFFF) begin errs++; $display("FAIL hold_quot got=%h exp=ffffffff", quotient); end
    vecs++; if (remainder !== 32'h0000_1234) begin errs++; $display("FAIL hold_rem got=%h exp=00001234", remainder); end
  endtask

  task automatic test_abort();
    int lat, gaps, seen;
    signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    clr = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy got=%b exp=0", busy); end
    vecs++; if (quotient !== 32'h0) begin errs++; $display("FAIL abort_quot got=%h exp=0", quotient); end
    vecs++; if (remainder !== 32'h0) begin errs++; $display("FAIL abort_rem got=%h exp=0", remainder); end
    vecs++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL abort_dbz got=%b exp=0", div_by_zero); end
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    do_op(1'b0, 32'd9, 32'd3, lat, gaps);
    vecs++; if (lat !== 34) begin errs++; $display("FAIL post_abort_latency got=%0d exp=34", lat); end
    vecs++; if (quotient !== 32'd3) begin errs++; $display("FAIL post_abort_quot got=%h exp=00000003", quotient); end
    vecs++; if (remainder !== 32'd0) begin errs++; $display("FAIL post_abort_rem got=%h exp=00000000", remainder); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dividend = 32'd50; divisor = 32'd5; signed_op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 7; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    vecs++; if (lat !== 34) begin errs++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
    vecs++; if (quotient !== 32'd14) begin errs++; $display("FAIL ignore_quot got=%h exp=0000000e", quotient); end
    vecs++; if (remainder !== 32'd2) begin errs++; $display("FAIL ignore_rem got=%h exp=00000002", remainder); end
  endtask

  task automatic test_back_to_back();
    int lat;
    signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    vecs++; if (lat !== 34) begin errs++; $display("FAIL b2b_first_latency got=%0d exp=34", lat); end
    vecs++; if (quotient !== 32'd14) begin errs++; $display("FAIL b2b_first_quot got=%h exp=0000000e", quotient); end
    // start still high: accepted at the very next edge with the new operands
    dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_second_busy got=%b exp=1", busy); end
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    vecs++; if (lat !== 34) begin errs++; $display("FAIL b2b_second_latency got=%0d exp=34", lat); end
    vecs++; if (quotient !== 32'd3) begin errs++; $display("FAIL b2b_second_quot got=%h exp=00000003", quotient); end
    vecs++; if (remainder !== 32'd0) begin errs++; $display("FAIL b2b_second_rem got=%h exp=00000000", remainder); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_hold();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high, named as the codebase names them: clk and clr.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
  clk  input  1  rising-edge clock
  clr  input  1  asynchronous active-high reset
  start  input  1  begin division; sampled only in IDLE
  signed_op  input  1  1 = signed div, 0 = unsigned divu; latched with start
  dividend  input  32  A operand; latched with start
  divisor  input  32  B operand; latched with start
  busy  output  1  high from the cycle after start is accepted until done
  done  output  1  one-cycle pulse; results valid
  div_by_zero  output  1  flag for the completed operation; held with results
  quotient  output  32  Z low / LO value
  remainder  output  32  Z high / HI value
REQ-003 The block SHALL have one parameter: WIDTH, default 32, operand width.

Function
REQ-004 The FSM SHALL have states IDLE, RUN, FIX, DONE.
REQ-005 IDLE with start=1 at an edge SHALL latch operands and signed_op, store absolute values when signed_op=1, clear the partial remainder, load iteration counter with WIDTH-1, and go to RUN.
REQ-006 IDLE with start=1 and divisor=0 SHALL go directly to DONE, skipping RUN and FIX.
REQ-007 RUN SHALL perform one restoring shift-subtract step per cycle: shift in the next dividend MSB, subtract, restore on negative, shift quotient bit in.
REQ-008 RUN SHALL take exactly WIDTH cycles, decrementing the counter, then go to FIX.
REQ-009 FIX SHALL apply signs in one cycle: quotient negated iff signed_op and operand signs differ; remainder takes dividend sign. FIX then goes to DONE.
REQ-010 DONE SHALL assert done for exactly one cycle, update quotient/remainder/div_by_zero, then return to IDLE.
REQ-011 Latency SHALL be fixed: done high in the cycle after edge k+WIDTH+2 (k+34 for WIDTH=32) when start is sampled at edge k; k+1 for divide-by-zero.
REQ-012 Quotient SHALL truncate toward zero; remainder SHALL satisfy dividend = quotient*divisor + remainder, modulo 2^WIDTH.
REQ-013 Divide-by-zero SHALL give quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-014 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-015 start asserted while busy SHALL be ignored; operand input changes after acceptance SHALL have no effect.
REQ-016 start held high across DONE SHALL be accepted again in the next IDLE cycle (back-to-back operation).
REQ-017 quotient, remainder, and div_by_zero SHALL hold their last values until the next DONE or clr.

Reset
REQ-018 clr=1 SHALL asynchronously force IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, and counter=0.
REQ-019 clr asserted mid-RUN or mid-FIX SHALL abort the operation with no done pulse; the first start after clr deasserts SHALL be accepted normally.

Structure
REQ-020 Package div_pkg SHALL hold the state encoding (IDLE, RUN, FIX, DONE), WIDTH default, and the div-by-zero quotient constant.
REQ-021 One sub-module div_step SHALL implement a single combinational restoring iteration (partial remainder, divisor -> next remainder, quotient bit); seq_divider SHALL hold all registers and the FSM.

Verification
REQ-022 Unsigned 100 / 7 -> quotient=0x0000000E, remainder=0x00000002, done 34 cycles after start, busy high during the 33 preceding cycles.
REQ-023 Signed -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; signed 100 / -7 -> quotient=0xFFFFFFF2, remainder=0x00000002.
REQ-024 Unsigned 0xFFFFFFFF / 2 -> quotient=0x7FFFFFFF, remainder=1; signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-025 0x00001234 / 0 -> done one cycle after start, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x00001234.
REQ-026 Start 100/7, pulse clr at RUN cycle 10 -> busy=0 and outputs 0 immediately, no done pulse; a new 9/3 start -> quotient=3, remainder=0.
REQ-027 Start 100/7, re-assert start with 50/5 while busy -> ignored, result 14 r 2; start held through DONE -> second op begins next cycle.
